button_step_gen: RTL and testbench

BUTTON_STEP_GEN -- requirements
Module: button_step_gen

---
 rtl/button_step_gen_pkg.sv | 19 +
 rtl/button_step_gen_btn_debounce.sv | 52 +++++
 rtl/button_step_gen.sv | 122 ++++++++++++
 tb/tb_button_step_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_step_gen_pkg.sv
// Shared types and constants for the button step generator.
package button_step_gen_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HOLD         = 2'd1,
        REPEAT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } step_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Debounce counter covers DEBOUNCE_CYCLES up to 255.
    localparam int unsigned DB_CNT_W  = 8;
    // Repeat counter covers REPEAT_DELAY / REPEAT_PERIOD up to 65535.
    localparam int unsigned REP_CNT_W = 16;

endpackage

// File: rtl/button_step_gen_btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
module btn_debounce
    import button_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                level_q, level_d;
    logic [DB_CNT_W-1:0] cnt_q,   cnt_d;

    // Synchronize, then count consecutive samples that disagree with the accepted level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_step_gen.sv
// Up/down button front end producing single step pulses with auto-repeat.
module button_step_gen
    import button_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic Inc,
    output logic UpDown,
    output logic held
);

    localparam logic [REP_CNT_W-1:0] DELAY_LAST  = REP_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [REP_CNT_W-1:0] PERIOD_LAST = REP_CNT_W'(REPEAT_PERIOD - 1);

    logic up_lvl;
    logic down_lvl;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up),
        .level   (up_lvl)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down),
        .level   (down_lvl)
    );

    step_state_e          state_q, state_d;
    logic                 inc_q,   inc_d;
    logic                 dir_q,   dir_d;
    logic                 held_q,  held_d;
    logic [REP_CNT_W-1:0] rep_q,   rep_d;
    logic                 mine;
    logic                 other;

    // Next-state and registered-output logic; the repeat counter restarts on every pulse.
    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        dir_d   = dir_q;
        rep_d   = rep_q;
        mine    = (dir_q == DIR_UP) ? up_lvl   : down_lvl;
        other   = (dir_q == DIR_UP) ? down_lvl : up_lvl;
        case (state_q)
            IDLE: begin
                rep_d = '0;
                if (up_lvl && down_lvl) begin
                    state_d = WAIT_RELEASE;
                end else if (up_lvl || down_lvl) begin
                    state_d = HOLD;
                    inc_d   = 1'b1;
                    dir_d   = up_lvl ? DIR_UP : DIR_DOWN;
                end
            end
            HOLD: begin
                if (!mine) begin
                    state_d = IDLE;
                end else if (other) begin
                    state_d = WAIT_RELEASE;
                end else if (rep_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    inc_d   = 1'b1;
                    rep_d   = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!mine) begin
                    state_d = IDLE;
                end else if (other) begin
                    state_d = WAIT_RELEASE;
                end else if (rep_q == PERIOD_LAST) begin
                    inc_d = 1'b1;
                    rep_d = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                rep_d = '0;
                if (!up_lvl && !down_lvl) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        held_d = (state_d == REPEAT);
    end

    // FSM and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            inc_q   <= 1'b0;
            dir_q   <= DIR_DOWN;
            held_q  <= 1'b0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            dir_q   <= dir_d;
            held_q  <= held_d;
            rep_q   <= rep_d;
        end
    end

    assign Inc    = inc_q;
    assign UpDown = dir_q;
    assign held   = held_q;

endmodule

// File: tb/tb_button_step_gen.sv
// Self-checking bench for button_step_gen: directed scenarios plus random stimulus against a behavioural model.
module tb_button_step_gen;

    localparam int DB   = 4;
    localparam int RD   = 8;
    localparam int RP   = 4;
    localparam int MAXE = 16383;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic Inc;
    logic UpDown;
    logic held;

    int n_checks = 0;
    int n_err    = 0;

    button_step_gen #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .Inc      (Inc),
        .UpDown   (UpDown),
        .held     (held)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw levels seen at each rising edge since reset; a level is accepted once
    // the last DB synchronized samples (raw delayed by two edges) all disagree with it.
    typedef enum {M_IDLE, M_ACTIVE, M_BLOCKED} mmode_e;

    bit     hu [0:MAXE];
    bit     hd [0:MAXE];
    int     n        = 0;
    bit     dbu      = 1'b0;
    bit     dbd      = 1'b0;
    mmode_e mode     = M_IDLE;
    bit     pdir     = 1'b0;
    int     press_n  = 0;
    int     el       = 0;
    bit     m_mine   = 1'b0;
    bit     m_other  = 1'b0;
    bit     exp_inc  = 1'b0;
    bit     exp_ud   = 1'b0;
    bit     exp_held = 1'b0;

    function automatic bit get_s(input bit up, input int idx);
        if (idx < 1 || idx > MAXE) return 1'b0;
        return up ? hu[idx] : hd[idx];
    endfunction

    function automatic bit settles(input bit up, input int last, input bit v);
        for (int k = 0; k < DB; k++)
            if (get_s(up, last - k) != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0; dbu = 0; dbd = 0; mode = M_IDLE;
            exp_inc = 0; exp_ud = 0; exp_held = 0;
        end else begin
            n++;
            if (n <= MAXE) begin
                hu[n] = btn_up;
                hd[n] = btn_down;
            end
            exp_inc = 0;
            case (mode)
                M_IDLE: begin
                    if (dbu && dbd) mode = M_BLOCKED;
                    else if (dbu || dbd) begin
                        mode = M_ACTIVE; pdir = dbu; press_n = n;
                        exp_inc = 1; exp_ud = dbu;
                    end
                end
                M_ACTIVE: begin
                    m_mine  = pdir ? dbu : dbd;
                    m_other = pdir ? dbd : dbu;
                    if (!m_mine) mode = M_IDLE;
                    else if (m_other) mode = M_BLOCKED;
                    else begin
                        el = n - press_n;
                        if (el == RD || (el > RD && (el - RD) % RP == 0)) exp_inc = 1;
                    end
                end
                default: if (!dbu && !dbd) mode = M_IDLE;
            endcase
            exp_held = (mode == M_ACTIVE) && ((n - press_n) >= RD);
            if (settles(1'b1, n - 2, !dbu)) dbu = !dbu;
            if (settles(1'b0, n - 2, !dbd)) dbd = !dbd;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            check("inc",    int'(Inc),    int'(exp_inc));
            check("updown", int'(UpDown), int'(exp_ud));
            check("held",   int'(held),   int'(exp_held));
        end
    end

    // Pulse log for directed literal expectations.
    int pulses[$];
    bit pulse_ud[$];
    bit held_seen = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (Inc) begin
                pulses.push_back(n);
                pulse_ud.push_back(UpDown);
            end
            if (held) held_seen = 1'b1;
        end
    end

    // Called just after a falling edge: reset mid-cycle, check async clear, release before edge 1.
    task automatic do_reset(input bit up, input bit dn);
        #3;
        reset    = 1'b0;
        btn_up   = up;
        btn_down = dn;
        #1;
        check("rst_inc",    int'(Inc),    0);
        check("rst_updown", int'(UpDown), 0);
        check("rst_held",   int'(held),   0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        pulses.delete();
        pulse_ud.delete();
        held_seen = 1'b0;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
        #2;
    endtask

    function automatic int pulse_at(input int i);
        return (i < pulses.size()) ? pulses[i] : -1;
    endfunction

    int exp2 [7] = '{7, 15, 19, 23, 27, 31, 35};
    int ups;

    initial begin
        // S1: clean short up press -> one pulse at edge 7
        @(negedge clk);
        do_reset(1'b1, 1'b0);
        cyc(5); btn_up = 0;
        cyc(20);
        check("s1_npulse", pulses.size(), 1);
        check("s1_edge", pulse_at(0), 7);
        check("s1_ud", (pulse_ud.size() > 0) ? int'(pulse_ud[0]) : -1, 1);
        check("s1_held_seen", int'(held_seen), 0);

        // S2: long down hold -> 7, 15, then every 4
        @(negedge clk);
        do_reset(1'b0, 1'b1);
        cyc(30); btn_down = 0;
        cyc(20);
        check("s2_npulse", pulses.size(), 7);
        for (int i = 0; i < 7; i++) check("s2_edge", pulse_at(i), exp2[i]);
        ups = 0;
        foreach (pulse_ud[i]) ups += int'(pulse_ud[i]);
        check("s2_ups", ups, 0);
        check("s2_held_seen", int'(held_seen), 1);
        check("s2_held_end", int'(held), 0);

        // S3: bounce every 2 cycles -> nothing
        @(negedge clk);
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(2); btn_up = ~btn_up;
        end
        btn_up = 0;
        cyc(12);
        check("s3_npulse", pulses.size(), 0);

        // S4: both together -> nothing; release; up alone -> one up pulse
        @(negedge clk);
        do_reset(1'b1, 1'b1);
        cyc(10); btn_up = 0; btn_down = 0;
        cyc(12); btn_up = 1;
        cyc(8);  btn_up = 0;
        cyc(15);
        check("s4_npulse", pulses.size(), 1);
        check("s4_ud", (pulse_ud.size() > 0) ? int'(pulse_ud[0]) : -1, 1);

        // S5: up into repeat, add down -> stop; release; down press -> one down pulse
        @(negedge clk);
        do_reset(1'b1, 1'b0);
        cyc(20); btn_down = 1;
        cyc(10); btn_up = 0; btn_down = 0;
        cyc(12); btn_down = 1;
        cyc(6);  btn_down = 0;
        cyc(15);
        check("s5_npulse", pulses.size(), 5);
        check("s5_last_edge_gap", pulse_at(3), 23);
        check("s5_last_ud", (pulse_ud.size() > 0) ? int'(pulse_ud[pulse_ud.size() - 1]) : -1, 0);

        // S6: reset during repeat with up held
        @(negedge clk);
        do_reset(1'b1, 1'b0);
        repeat (19) @(negedge clk);
        check("s6_pre_inc",  int'(Inc),    1);
        check("s6_pre_held", int'(held),   1);
        check("s6_pre_ud",   int'(UpDown), 1);
        do_reset(1'b1, 1'b0);
        cyc(20);
        check("s6_npulse", pulses.size(), 3);
        check("s6_edge0", pulse_at(0), 7);
        check("s6_edge1", pulse_at(1), 15);
        check("s6_edge2", pulse_at(2), 19);
        btn_up = 0;
        cyc(10);

        // Random phase: model-checked every cycle
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            case ($urandom_range(0, 5))
                0, 1: begin btn_up = 1; btn_down = 0; end
                2, 3: begin btn_up = 0; btn_down = 1; end
                4:    begin btn_up = 1; btn_down = 1; end
                default: begin btn_up = 0; btn_down = 0; end
            endcase
            if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 3));
            else cyc($urandom_range(4, 30));
        end
        btn_up = 0; btn_down = 0;
        cyc(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
